// File: rtl/adc_sample_packer.sv
// adc_sample_packer: packs ADC samples into capture FIFO words.
// Arm/trigger FSM with offset, decimation, flush and overflow.
//
// Ports:
//   adc_sampleclk, reset_i        clock, async active-low reset
//   adc_datain/adc_or/adc_trig_status  sample, over-range, trigger level
//   arm_i, trigger_i              capture enable level, trigger pulse
//   offset_i, decimate_i, max_samples_i  capture controls
//   word_o, word_valid_o, word_ready_i   FIFO write side
//   overflow_o, capture_done_o, samples_captured_o  status
module adc_sample_packer #(
    parameter int ADC_WIDTH        = 10,
    parameter int SAMPLES_PER_WORD = 3,
    parameter int WORD_WIDTH       = 32,
    parameter int CNT_WIDTH        = 32,
    parameter int DECIM_WIDTH      = 16
) (
    input  logic                   adc_sampleclk,
    input  logic                   reset_i,
    input  logic [ADC_WIDTH-1:0]   adc_datain,
    input  logic                   adc_or,
    input  logic                   adc_trig_status,
    input  logic                   arm_i,
    input  logic                   trigger_i,
    input  logic [CNT_WIDTH-1:0]   offset_i,
    input  logic [DECIM_WIDTH-1:0] decimate_i,
    input  logic [CNT_WIDTH-1:0]   max_samples_i,
    output logic [WORD_WIDTH-1:0]  word_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic                   overflow_o,
    output logic                   capture_done_o,
    output logic [CNT_WIDTH-1:0]   samples_captured_o
);

    localparam int LW =
        (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_OFFSET,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]   off_cnt;
    logic [CNT_WIDTH-1:0]   smp_cnt;
    logic [DECIM_WIDTH-1:0] dec_cnt;
    logic [LW-1:0]          lane;
    logic [WORD_WIDTH-1:0]  acc;
    logic [WORD_WIDTH-1:0]  acc_nxt;
    logic [WORD_WIDTH-1:0]  word_nxt;
    logic [WORD_WIDTH-1:0]  word_r;
    logic                   or_acc;
    logic                   or_nxt;
    logic                   valid_r;
    logic                   ovf_r;
    logic                   accept;
    logic                   last_smp;
    logic                   lane_full;
    logic                   emit;
    logic                   arm_clr;

    always_ff @(posedge adc_sampleclk or negedge reset_i) begin
        if (!reset_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!arm_i) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   state_nxt = S_ARMED;
                S_ARMED: begin
                    if (trigger_i) begin
                        if (max_samples_i == '0)
                            state_nxt = S_DONE;
                        else if (offset_i == '0)
                            state_nxt = S_CAPTURE;
                        else
                            state_nxt = S_OFFSET;
                    end
                end
                S_OFFSET: begin
                    if (off_cnt == '0) state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    // The partial word is already registered here;
                    // FLUSH is the cycle its strobe is visible.
                    if (accept && last_smp)
                        state_nxt = lane_full ? S_DONE : S_FLUSH;
                end
                S_FLUSH:  state_nxt = S_DONE;
                S_DONE:   state_nxt = S_DONE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        capture_done_o = (state == S_DONE);
        arm_clr   = (state == S_IDLE) && arm_i;
        accept    = arm_i && (state == S_CAPTURE)
                    && (dec_cnt == '0);
        last_smp  = (smp_cnt + CNT_WIDTH'(1)) == max_samples_i;
        lane_full = (lane == LW'(SAMPLES_PER_WORD - 1));
        emit      = accept && (lane_full || last_smp);
        acc_nxt   = acc | (WORD_WIDTH'(adc_datain)
                    << (int'(lane) * ADC_WIDTH));
        or_nxt    = or_acc | adc_or;
        word_nxt  = acc_nxt;
        word_nxt[WORD_WIDTH-1] = or_nxt;
        word_nxt[WORD_WIDTH-2] = adc_trig_status;
    end

    always_ff @(posedge adc_sampleclk or negedge reset_i) begin
        if (!reset_i) begin
            off_cnt <= '0;
            smp_cnt <= '0;
            dec_cnt <= '0;
            lane    <= '0;
            acc     <= '0;
            or_acc  <= 1'b0;
            word_r  <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            valid_r <= emit;
            if (emit) word_r <= word_nxt;
            // Loaded every ARMED cycle; only the trigger cycle matters.
            if (state == S_ARMED)
                off_cnt <= offset_i - CNT_WIDTH'(1);
            else if (state == S_OFFSET)
                off_cnt <= off_cnt - CNT_WIDTH'(1);
            if (arm_clr) begin
                smp_cnt <= '0;
                dec_cnt <= '0;
                lane    <= '0;
                acc     <= '0;
                or_acc  <= 1'b0;
                ovf_r   <= 1'b0;
            end else begin
                if (valid_r && !word_ready_i) ovf_r <= 1'b1;
                if (arm_i && state == S_CAPTURE) begin
                    if (dec_cnt == '0) dec_cnt <= decimate_i;
                    else dec_cnt <= dec_cnt - DECIM_WIDTH'(1);
                end
                if (accept) begin
                    smp_cnt <= smp_cnt + CNT_WIDTH'(1);
                    if (emit) begin
                        lane   <= '0;
                        acc    <= '0;
                        or_acc <= 1'b0;
                    end else begin
                        lane   <= lane + LW'(1);
                        acc    <= acc_nxt;
                        or_acc <= or_nxt;
                    end
                end
            end
        end
    end

    assign word_o             = word_r;
    assign word_valid_o       = valid_r;
    assign overflow_o         = ovf_r;
    assign samples_captured_o = smp_cnt;

endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: directed bench with a schedule-level model.
// Model derives per-cycle expectations from trigger/offset/decimation.
module tb_adc_sample_packer;

    localparam int AW    = 10;
    localparam int SPW   = 3;
    localparam int WW    = 32;
    localparam int CW    = 32;
    localparam int DW    = 16;
    localparam int NCMAX = 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [AW-1:0] adc_datain;
    logic          adc_or;
    logic          adc_trig_status;
    logic          arm_i;
    logic          trigger_i;
    logic [CW-1:0] offset_i;
    logic [DW-1:0] decimate_i;
    logic [CW-1:0] max_samples_i;
    logic [WW-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic          overflow_o;
    logic          capture_done_o;
    logic [CW-1:0] samples_captured_o;

    always #5 clk = ~clk;

    adc_sample_packer #(
        .ADC_WIDTH(AW), .SAMPLES_PER_WORD(SPW), .WORD_WIDTH(WW),
        .CNT_WIDTH(CW), .DECIM_WIDTH(DW)
    ) dut (
        .adc_sampleclk(clk),
        .reset_i(reset_i),
        .adc_datain(adc_datain),
        .adc_or(adc_or),
        .adc_trig_status(adc_trig_status),
        .arm_i(arm_i),
        .trigger_i(trigger_i),
        .offset_i(offset_i),
        .decimate_i(decimate_i),
        .max_samples_i(max_samples_i),
        .word_o(word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .overflow_o(overflow_o),
        .capture_done_o(capture_done_o),
        .samples_captured_o(samples_captured_o)
    );

    int tests = 0;
    int fails = 0;
    int cur = 0;
    bit chk = 1'b0;

    logic          ev [NCMAX];
    logic [WW-1:0] ew [NCMAX];
    logic          ed [NCMAX];
    int            ec [NCMAX];
    logic          eo [NCMAX];
    int            prev_cnt = 0;
    logic          prev_ovf = 1'b0;
    int            drop_c = -1;

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h",
                     name, cur, act, exp);
        end
    endtask

    function automatic logic tstat(int c);
        return (c % 2) == 1;
    endfunction

    // Expected schedule: candidate cycles start at T+1+off, every
    // (dec+1)-th is accepted, grouped SPW per word, strobe one
    // cycle after the group's last sample.
    task automatic build(int T, int off, int dec, int mx, int or_v,
                         int drop_w, int A, int NC);
        int ck[$];
        int ds;
        int g;
        drop_c = -1;
        ds = NCMAX + 10;
        for (int c = 0; c < NCMAX; c++) begin
            ev[c] = 1'b0;
            ew[c] = '0;
            ed[c] = 1'b0;
            ec[c] = 0;
            eo[c] = 1'b0;
        end
        if (mx > 0)
            for (int k = 0; k < mx; k++) begin
                int c;
                c = T + 1 + off + k * (dec + 1);
                if (c >= A) break;
                ck.push_back(c);
            end
        g = 0;
        for (int lo = 0; lo < ck.size(); lo += SPW) begin
            int hi;
            int wc;
            logic [WW-1:0] w;
            hi = lo + SPW - 1;
            if (hi > ck.size() - 1) hi = ck.size() - 1;
            if ((hi - lo + 1 == SPW) || (hi == mx - 1)) begin
                w = '0;
                for (int i = lo; i <= hi; i++) begin
                    int v;
                    v = ck[i] - T;
                    w = w | (WW'(v) << ((i - lo) * AW));
                    if (v == or_v) w[WW-1] = 1'b1;
                end
                w[WW-2] = tstat(ck[hi]);
                wc = ck[hi] + 1;
                ev[wc] = 1'b1;
                ew[wc] = w;
                if (g == drop_w) drop_c = wc;
                g++;
            end
        end
        if (mx == 0)
            ds = T + 1;
        else if (ck.size() == mx)
            ds = (mx % SPW == 0) ? ck[mx-1] + 1 : ck[mx-1] + 2;
        for (int c = 1; c < NC; c++) begin
            int n;
            n = 0;
            foreach (ck[i]) if (ck[i] < c) n++;
            ec[c] = n;
            ed[c] = (c >= ds) && (c <= A);
            eo[c] = (drop_c >= 0) && (c > drop_c);
        end
        ec[0] = prev_cnt;
        eo[0] = prev_ovf;
        prev_cnt = ec[NC-1];
        prev_ovf = eo[NC-1];
    endtask

    task automatic run(int T, int off, int dec, int mx, int or_v,
                       int drop_w, int A, int NC, int rt);
        build(T, off, dec, mx, or_v, drop_w, A, NC);
        offset_i      = CW'(off);
        decimate_i    = DW'(dec);
        max_samples_i = CW'(mx);
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            cur             = c;
            arm_i           = (c < A);
            trigger_i       = (c == T) || (c == rt);
            adc_datain      = (c > T) ? AW'(c - T) : '0;
            adc_or          = (c > T) && (c - T == or_v);
            adc_trig_status = tstat(c);
            word_ready_i    = (c != drop_c);
            chk             = 1'b1;
        end
        @(posedge clk);
        #1;
        chk       = 1'b0;
        arm_i     = 1'b0;
        trigger_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("valid", 64'(word_valid_o), 64'(ev[cur]));
            if (ev[cur]) check("word", 64'(word_o), 64'(ew[cur]));
            check("done", 64'(capture_done_o), 64'(ed[cur]));
            check("count", 64'(samples_captured_o), 64'(ec[cur]));
            check("ovf", 64'(overflow_o), 64'(eo[cur]));
        end
    end

    task automatic check_zero(string tag);
        check({tag, "_word"}, 64'(word_o), 64'd0);
        check({tag, "_valid"}, 64'(word_valid_o), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        check({tag, "_done"}, 64'(capture_done_o), 64'd0);
        check({tag, "_count"}, 64'(samples_captured_o), 64'd0);
    endtask

    initial begin
        reset_i         = 1'b0;
        adc_datain      = '0;
        adc_or          = 1'b0;
        adc_trig_status = 1'b0;
        arm_i           = 1'b0;
        trigger_i       = 1'b0;
        offset_i        = '0;
        decimate_i      = '0;
        max_samples_i   = '0;
        word_ready_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset_i = 1'b1;

        // two full words, OR on sample 2, trig level toggling
        run(2, 0, 0, 6, 2, -1, 13, 16, 11);
        check("pin_w0", 64'(ew[6]), 64'h0000_0000_C030_0801);
        check("pin_w1", 64'(ew[9]), 64'h0000_0000_0060_1404);

        // partial word flush
        run(2, 0, 0, 7, 0, -1, 15, 18, -1);
        check("pin_flush", 64'(ew[10]), 64'h0000_0000_4000_0007);
        check("pin_cnt7", 64'(ec[17]), 64'd7);

        // offset + decimation, retrigger ignored
        run(2, 5, 2, 3, 0, -1, 19, 22, 10);
        check("pin_decim", 64'(ew[15]), 64'h0000_0000_00C0_2406);

        // second word dropped by backpressure
        run(2, 0, 0, 9, 0, 1, 15, 18, -1);
        check("pin_ovf", 64'(eo[17]), 64'd1);
        check("pin_cnt9", 64'(ec[17]), 64'd9);

        // abort after four samples; re-arm clears sticky status
        run(2, 0, 0, 9, 0, -1, 7, 12, -1);
        check("pin_abort_cnt", 64'(ec[11]), 64'd4);

        // zero samples requested
        run(2, 0, 0, 0, 0, -1, 8, 11, 4);
        check("pin_max0", 64'(ed[5]), 64'd1);

        // async reset in the middle of a capture
        offset_i      = '0;
        decimate_i    = '0;
        max_samples_i = CW'(20);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            arm_i      = 1'b1;
            trigger_i  = (c == 2);
            adc_datain = AW'(c);
        end
        check("pre_rst_count", 64'(samples_captured_o), 64'd5);
        #2;
        reset_i = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        check_zero("midrst_hold");
        arm_i   = 1'b0;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Parametrised successor to the fixed 3×10-bit ADC packer in the capture front end.
- Packs SAMPLES_PER_WORD ADC samples of ADC_WIDTH bits into one WORD_WIDTH word and pushes each word to the capture FIFO write port.
- Adds an arm/trigger state machine, post-trigger offset, decimation, partial-word flush and overflow detection.
- Single clock domain: runs entirely on the ADC sample clock, upstream of the dual-clock FIFO.

Parameters:
ADC_WIDTH, 10, bits per ADC sample
SAMPLES_PER_WORD, 3, sample lanes per packed word (1..8)
WORD_WIDTH, 32, output word width; must be ≥ ADC_WIDTH*SAMPLES_PER_WORD+2
CNT_WIDTH, 32, width of sample/offset counters
DECIM_WIDTH, 16, width of decimation control

Ports:
adc_sampleclk  in  1  sole clock, rising edge
reset_i  in  1  asynchronous, active-low reset
adc_datain  in  ADC_WIDTH  ADC sample
adc_or  in  1  ADC over-range
adc_trig_status  in  1  trigger level, recorded per word
arm_i  in  1  level; 1 = capture enabled, 0 = abort/return to IDLE
trigger_i  in  1  single-cycle trigger pulse
offset_i  in  CNT_WIDTH  ADC clocks to skip after trigger
decimate_i  in  DECIM_WIDTH  keep 1 of every decimate_i+1 samples
max_samples_i  in  CNT_WIDTH  samples to capture
word_o  out  WORD_WIDTH  packed word
word_valid_o  out  1  one-cycle write strobe for word_o
word_ready_i  in  1  sink can accept (FIFO not full)
overflow_o  out  1  sticky: a word was dropped
capture_done_o  out  1  capture complete
samples_captured_o  out  CNT_WIDTH  accepted sample count

Behaviour:
- Reset (reset_i=0, async): state IDLE; all outputs 0; all counters 0.
- Word format:
  - lane k (k=0 first sample) at bits [k*ADC_WIDTH +: ADC_WIDTH].
  - bit WORD_WIDTH-1 = OR of adc_or over the word's accepted samples.
  - bit WORD_WIDTH-2 = adc_trig_status at the word's last accepted sample.
  - Unused bits and unfilled lanes are 0.
- IDLE: arm_i=1 → ARMED next cycle. Entering ARMED clears overflow_o, samples_captured_o, the lane index and the decimation counter.
- ARMED, trigger_i=1 at cycle t:
  - max_samples_i=0 → DONE.
  - offset_i=0 → CAPTURE.
  - otherwise → OFFSET.
- OFFSET: counts offset_i clocks, then → CAPTURE. For any offset, the first candidate sample is adc_datain at cycle t+1+offset_i.
- CAPTURE: each cycle is a candidate.
  - Decimation counter starts at 0. A candidate is accepted when the counter = 0; the counter then reloads to decimate_i. Otherwise it decrements.
  - decimate_i=0 accepts every cycle.
  - An accepted sample goes into the current lane; the lane index increments and samples_captured_o increments.
- Word emission: when the lane index reaches SAMPLES_PER_WORD, word_o is registered and word_valid_o=1 for exactly one cycle at c+1 (c = completing sample cycle). The lane index returns to 0 with no bubble.
- Stop: when samples_captured_o reaches max_samples_i:
  - with the final word just emitted → DONE;
  - with a partial word pending → FLUSH.
- FLUSH: emits the partial word (unfilled lanes 0, word_valid_o one cycle), then → DONE.
- DONE: capture_done_o=1; ignores trigger_i; stays until arm_i=0.
- arm_i=0 in any state: → IDLE next cycle. Any partial word is discarded without emission. capture_done_o clears. overflow_o and samples_captured_o hold until the next arm.
- Backpressure: word_ready_i is sampled in the word_valid_o cycle.
  - If 0, the word is lost and overflow_o sets next cycle (sticky).
  - Capture continues; samples still count.
- Simultaneous events:
  - trigger_i while arm_i=0 → ignored.
  - trigger_i in OFFSET/CAPTURE → ignored (no retrigger).
  - Async reset mid-capture → immediate IDLE; no word_valid_o.

Test Plan:
- Defaults, decimate=0, offset=0, max=6, trigger at t, data ramp 1,2,3… from t+1 → word_valid_o at t+4 and t+7. First word lanes = {1,2,3}, second = {4,5,6}. Then capture_done_o=1.
- max=7, same ramp → third word (FLUSH) lane0=7, lanes1-2=0. capture_done_o follows the flush cycle. samples_captured_o=7.
- offset=5, decimate=2, max=3, ramp starting 1 at t+1 → accepted samples 6,9,12 packed in one word.
- word_ready_i=0 during the second word's strobe, max=9 → overflow_o=1 after that cycle. Three strobes still occur. samples_captured_o=9.
- adc_or=1 only on sample 2 → word0 bit31=1, word1 bit31=0. adc_trig_status toggled → bit30 matches the level at samples 3/6.
- arm_i dropped after 4 accepted samples → one word emitted, partial lane discarded, state IDLE. Re-arm clears overflow_o and samples_captured_o. Also assert reset_i=0 mid-capture → outputs 0 at once.
